// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response codes, byte-lane width and address-to-register decode
package axi4_lite_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;
  localparam int BYTE_BITS = 8;
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr, input int data_size);
    return addr >> $clog2(data_size / BYTE_BITS);
  endfunction
endpackage

// File: rtl/axi4_lite_aw_w_joiner.sv
// axi4_lite_aw_w_joiner: holds AW and W independently until both are present and consumed
module axi4_lite_aw_w_joiner
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_clk_i,
  input  logic [ADDRESS_SIZE-1:0]        awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_SIZE-1:0]           wdata,
  input  logic [DATA_SIZE/BYTE_BITS-1:0] wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic                           valid,
  output logic [ADDRESS_SIZE-1:0]        addr,
  output logic [DATA_SIZE-1:0]           data,
  output logic [DATA_SIZE/BYTE_BITS-1:0] strb,
  input  logic                           consume
);
  logic aw_held, w_held;
  assign awready = !aw_held;
  assign wready = !w_held;
  assign valid = aw_held && w_held;
  // consume only happens with both held, so no handshake can coincide with it
  always_ff @(posedge clk_i) begin
    if (rst_clk_i || consume) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        addr <= awaddr;
      end
      if (wvalid && wready) begin
        w_held <= 1'b1;
        data <= wdata;
        strb <= wstrb;
      end
    end
  end
endmodule

// File: rtl/axi4_lite_regfile_v3.sv
// axi4_lite_regfile_v3: AXI4-Lite register file with decode errors, read-only masking and hardware update ports
module axi4_lite_regfile_v3
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int REGISTERS = 4,
  parameter logic [REGISTERS-1:0] READ_ONLY_MASK = '0,
  parameter logic [REGISTERS*DATA_SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_clk_i,
  input  logic [ADDRESS_SIZE-1:0]        s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_SIZE-1:0]           s_axi_wdata,
  input  logic [DATA_SIZE/BYTE_BITS-1:0] s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDRESS_SIZE-1:0]        s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_SIZE-1:0]           s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [REGISTERS*DATA_SIZE-1:0] regs_o,
  output logic [REGISTERS-1:0]           reg_written_o,
  input  logic [REGISTERS-1:0]           hw_we_i,
  input  logic [REGISTERS*DATA_SIZE-1:0] hw_wdata_i
);
  localparam int STRB = DATA_SIZE / BYTE_BITS;
  logic j_valid, commit;
  logic [ADDRESS_SIZE-1:0] j_addr;
  logic [DATA_SIZE-1:0] j_data, r_mux;
  logic [STRB-1:0] j_strb;
  logic [DATA_SIZE-1:0] regs_q [REGISTERS];
  logic [REGISTERS-1:0] w_hit, r_hit;
  logic [63:0] w_idx, r_idx;
  resp_t bresp_q, rresp_q;
  axi4_lite_aw_w_joiner #(.ADDRESS_SIZE(ADDRESS_SIZE), .DATA_SIZE(DATA_SIZE)) u_join (
    .clk_i(clk_i), .rst_clk_i(rst_clk_i),
    .awaddr(s_axi_awaddr), .awvalid(s_axi_awvalid), .awready(s_axi_awready),
    .wdata(s_axi_wdata), .wstrb(s_axi_wstrb), .wvalid(s_axi_wvalid), .wready(s_axi_wready),
    .valid(j_valid), .addr(j_addr), .data(j_data), .strb(j_strb), .consume(commit)
  );
  assign commit = j_valid && !s_axi_bvalid;
  assign w_idx = addr_to_index(64'(j_addr), DATA_SIZE);
  assign r_idx = addr_to_index(64'(s_axi_araddr), DATA_SIZE);
  assign s_axi_arready = !s_axi_rvalid;
  assign s_axi_bresp = bresp_q;
  assign s_axi_rresp = rresp_q;
  // an empty w_hit covers both out-of-range and read-only targets; r_mux stays zero on a miss
  always_comb begin
    w_hit = '0;
    r_hit = '0;
    r_mux = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      w_hit[i] = w_idx == 64'(i) && !READ_ONLY_MASK[i];
      r_hit[i] = r_idx == 64'(i);
      r_mux = r_mux | (r_hit[i] ? regs_q[i] : '0);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_clk_i) begin
      for (int i = 0; i < REGISTERS; i++) regs_q[i] <= RESET_VALUE[i*DATA_SIZE +: DATA_SIZE];
      s_axi_bvalid <= 1'b0;
      bresp_q <= OKAY;
      s_axi_rvalid <= 1'b0;
      rresp_q <= OKAY;
      s_axi_rdata <= '0;
      reg_written_o <= '0;
    end else begin
      for (int i = 0; i < REGISTERS; i++) begin
        if (hw_we_i[i]) regs_q[i] <= hw_wdata_i[i*DATA_SIZE +: DATA_SIZE];
        else if (commit && w_hit[i])
          for (int b = 0; b < STRB; b++)
            if (j_strb[b]) regs_q[i][b*BYTE_BITS +: BYTE_BITS] <= j_data[b*BYTE_BITS +: BYTE_BITS];
      end
      reg_written_o <= commit ? w_hit : '0;
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        bresp_q <= |w_hit ? OKAY : SLVERR;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        rresp_q <= |r_hit ? OKAY : SLVERR;
        s_axi_rdata <= r_mux;
      end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  end
  for (genvar i = 0; i < REGISTERS; i++) begin : g_out
    assign regs_o[i*DATA_SIZE +: DATA_SIZE] = regs_q[i];
  end
endmodule

// File: tb/tb_axi4_lite_regfile_v3.sv
// tb_axi4_lite_regfile_v3: randomized and directed checks of the register file against a byte-level model
module tb_axi4_lite_regfile_v3;
  localparam int AW = 32, DW = 32, NR = 4;
  localparam logic [NR-1:0] RO = 4'b0010;
  localparam logic [NR*DW-1:0] RV = {32'h0000_0000, 32'hAABB_CCDD, 32'hDEAD_BEEF, 32'h1234_5678};
  logic clk = 0, rst = 1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [DW-1:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] regs, hw_wdata = '0;
  logic [NR-1:0] reg_written, hw_we = '0;
  logic [DW-1:0] model [NR];
  int pulses [NR] = '{default: 0};
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  axi4_lite_regfile_v3 #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .REGISTERS(NR),
                         .READ_ONLY_MASK(RO), .RESET_VALUE(RV)) dut (
    .clk_i(clk), .rst_clk_i(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .regs_o(regs), .reg_written_o(reg_written), .hw_we_i(hw_we), .hw_wdata_i(hw_wdata)
  );
  always @(negedge clk) for (int i = 0; i < NR; i++) if (reg_written[i]) pulses[i]++;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) model[i] = RV[i*DW +: DW];
  endfunction
  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction
  function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    int idx = int'(a / 4);
    logic [DW-1:0] m = '0;
    if (idx >= NR || RO[idx]) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    model[idx] = (model[idx] & ~m) | (d & m);
    return 2'b00;
  endfunction
  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    int idx = int'(a / 4);
    return idx < NR ? model[idx] : '0;
  endfunction

  task automatic send_aw(input logic [AW-1:0] a);
    @(negedge clk);
    awaddr = a; awvalid = 1;
    for (int k = 0; k < 20 && !awready; k++) @(negedge clk);
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL aw_accept awready=%b required 1", awready); end
    @(posedge clk); #1 awvalid = 0;
  endtask
  task automatic send_w(input logic [DW-1:0] d, input logic [3:0] s);
    @(negedge clk);
    wdata = d; wstrb = s; wvalid = 1;
    for (int k = 0; k < 20 && !wready; k++) @(negedge clk);
    checks++;
    if (wready !== 1'b1) begin errors++; $display("FAIL w_accept wready=%b required 1", wready); end
    @(posedge clk); #1 wvalid = 0;
  endtask
  task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    @(negedge clk);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    for (int k = 0; k < 20 && !(awready && wready); k++) @(negedge clk);
    checks++;
    if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL aw_w_accept ready=%b required 11", {awready, wready}); end
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
  endtask
  task automatic get_b(output logic [1:0] r);
    @(negedge clk);
    bready = 1;
    for (int k = 0; k < 20 && !bvalid; k++) @(negedge clk);
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL b_timeout bvalid=%b required 1", bvalid); end
    r = bresp;
    @(posedge clk); #1 bready = 0;
  endtask
  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r, output logic prompt);
    @(negedge clk);
    araddr = a; arvalid = 1;
    for (int k = 0; k < 20 && !arready; k++) @(negedge clk);
    @(posedge clk); #1 arvalid = 0;
    prompt = rvalid;
    for (int k = 0; k < 20 && !rvalid; k++) @(negedge clk);
    @(negedge clk);
    d = rdata; r = rresp; rready = 1;
    @(posedge clk); #1 rready = 0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d; logic [1:0] r; logic p;
    rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    model_reset();
    checks++;
    if (regs !== RV) begin errors++; $display("FAIL reset_regs got=%h required=%h", regs, RV); end
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, reg_written} !== {5'b11100, 4'b0}) begin
      errors++; $display("FAIL reset_ctrl got=%b required=111000000", {awready, wready, arready, bvalid, rvalid, reg_written});
    end
    checks++;
    if ({bresp, rresp, rdata} !== '0) begin errors++; $display("FAIL reset_resp got=%h required 0", {bresp, rresp, rdata}); end
    do_read(32'h4, d, r, p);
    checks++;
    if ({p, r, d} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL reset_read got=%b/%b/%h required 1/00/deadbeef", p, r, d);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r, er; int p0 = pulses[2];
    send_w(32'h1122_3344, 4'b0101);
    repeat (2) @(negedge clk);
    send_aw(32'h8);
    er = model_write(32'h8, 32'h1122_3344, 4'b0101);
    get_b(r);
    repeat (2) @(negedge clk);
    checks++;
    if (r !== er) begin errors++; $display("FAIL wfirst_bresp got=%b required=%b", r, er); end
    checks++;
    if (regs[2*DW +: DW] !== 32'hAA22_CC44) begin errors++; $display("FAIL wfirst_reg2 got=%h required=aa22cc44", regs[2*DW +: DW]); end
    checks++;
    if (pulses[2] - p0 !== 1) begin errors++; $display("FAIL wfirst_pulse got=%0d required=1", pulses[2] - p0); end
  endtask

  task automatic test_decode_err();
    logic [1:0] r; logic [DW-1:0] d; logic p;
    send_aw_w(32'h100, $urandom(), 4'hF);
    get_b(r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp got=%b required=10", r); end
    checks++;
    if (regs !== model_flat()) begin errors++; $display("FAIL oor_regs got=%h required=%h", regs, model_flat()); end
    do_read(32'h100, d, r, p);
    checks++;
    if ({d, r} !== {32'h0, 2'b10}) begin errors++; $display("FAIL oor_read got=%h/%b required=0/10", d, r); end
  endtask

  task automatic test_read_only();
    logic [1:0] r; logic [DW-1:0] d; logic p; int p0 = pulses[1];
    send_aw_w(32'h4, 32'h0BAD_F00D, 4'hF);
    get_b(r);
    @(negedge clk);
    checks++;
    if (r !== model_write(32'h4, 32'h0BAD_F00D, 4'hF)) begin errors++; $display("FAIL ro_bresp got=%b required=10", r); end
    checks++;
    if (regs !== model_flat() || pulses[1] != p0) begin
      errors++; $display("FAIL ro_nochange regs=%h required=%h pulses=%0d", regs, model_flat(), pulses[1] - p0);
    end
    do_read(32'h4, d, r, p);
    checks++;
    if ({d, r} !== {exp_rdata(32'h4), 2'b00}) begin errors++; $display("FAIL ro_read got=%h/%b required=%h/00", d, r, exp_rdata(32'h4)); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r;
    bready = 0;
    send_aw_w(32'h0, 32'hCAFE_0001, 4'hF);
    void'(model_write(32'h0, 32'hCAFE_0001, 4'hF));
    for (int k = 0; k < 10 && !bvalid; k++) @(negedge clk);
    send_aw_w(32'hC, 32'hCAFE_0003, 4'hF);
    void'(model_write(32'hC, 32'hCAFE_0003, 4'hF));
    repeat (5) @(negedge clk);
    checks++;
    if ({bvalid, awready, wready} !== 3'b100) begin errors++; $display("FAIL b2b_hold got=%b required=100", {bvalid, awready, wready}); end
    checks++;
    if (regs[3*DW +: DW] !== RV[3*DW +: DW]) begin errors++; $display("FAIL b2b_early got=%h required=%h", regs[3*DW +: DW], RV[3*DW +: DW]); end
    bready = 1;
    @(posedge clk); #1 bready = 0;
    checks++;
    if ({bvalid, awready} !== 2'b00) begin errors++; $display("FAIL b2b_gap got=%b required=00", {bvalid, awready}); end
    @(posedge clk); #1;
    checks++;
    if ({bvalid, bresp, awready, wready} !== 5'b10011) begin
      errors++; $display("FAIL b2b_second got=%b required=10011", {bvalid, bresp, awready, wready});
    end
    get_b(r);
    checks++;
    if (regs !== model_flat()) begin errors++; $display("FAIL b2b_regs got=%h required=%h", regs, model_flat()); end
  endtask

  task automatic test_collision();
    logic [1:0] r; logic [DW-1:0] d, old; int p3 = pulses[3];
    old = model[0];
    send_aw_w(32'h0, 32'h7777_7777, 4'hF);
    araddr = 32'h0; arvalid = 1;
    @(posedge clk); #1 arvalid = 0;
    d = rdata;
    rready = 1;
    @(posedge clk); #1 rready = 0;
    void'(model_write(32'h0, 32'h7777_7777, 4'hF));
    checks++;
    if (d !== old) begin errors++; $display("FAIL rw_old got=%h required=%h", d, old); end
    get_b(r);
    send_aw_w(32'hC, 32'h9, 4'hF);
    hw_we = 4'b1000; hw_wdata[3*DW +: DW] = 32'h5;
    @(posedge clk); #1 hw_we = 0;
    model[3] = 32'h5;
    get_b(r);
    @(negedge clk);
    checks++;
    if (r !== 2'b00 || pulses[3] - p3 !== 1) begin errors++; $display("FAIL hw_bus_resp got=%b/%0d required=00/1", r, pulses[3] - p3); end
    checks++;
    if (regs !== model_flat()) begin errors++; $display("FAIL hw_bus_regs got=%h required=%h", regs, model_flat()); end
    @(negedge clk);
    hw_we = 4'b0010; hw_wdata[DW +: DW] = 32'h600D_0001;
    @(negedge clk);
    hw_we = 0;
    model[1] = 32'h600D_0001;
    checks++;
    if (regs !== model_flat()) begin errors++; $display("FAIL hw_ro_update got=%h required=%h", regs, model_flat()); end
  endtask

  task automatic test_random();
    logic [1:0] r, er; logic [DW-1:0] d; logic p;
    logic [AW-1:0] a; logic [DW-1:0] wd; logic [3:0] s; int mode, gap;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, 31)); wd = $urandom(); s = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 2); gap = $urandom_range(0, 3);
      if (mode == 0) send_aw_w(a, wd, s);
      else if (mode == 1) begin send_w(wd, s); repeat (gap) @(negedge clk); send_aw(a); end
      else begin send_aw(a); repeat (gap) @(negedge clk); send_w(wd, s); end
      er = model_write(a, wd, s);
      get_b(r);
      checks++;
      if (r !== er) begin errors++; $display("FAIL rnd_bresp addr=%h got=%b required=%b", a, r, er); end
      checks++;
      if (regs !== model_flat()) begin errors++; $display("FAIL rnd_regs addr=%h got=%h required=%h", a, regs, model_flat()); end
      a = AW'($urandom_range(0, 31));
      do_read(a, d, r, p);
      checks++;
      if ({p, d, r} !== {1'b1, exp_rdata(a), (a / 4 < NR) ? 2'b00 : 2'b10}) begin
        errors++; $display("FAIL rnd_read addr=%h got=%b/%h/%b required=1/%h", a, p, d, r, exp_rdata(a));
      end
    end
  endtask

  task automatic test_reset_pending_read();
    @(negedge clk);
    araddr = 32'h8; arvalid = 1;
    @(posedge clk); #1 arvalid = 0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL pend_rvalid got=%b required=1", rvalid); end
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    checks++;
    if ({rvalid, arready} !== 2'b01 || regs !== model_flat()) begin
      errors++; $display("FAIL pend_reset rv/ar=%b required=01 regs=%h required=%h", {rvalid, arready}, regs, model_flat());
    end
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_w_before_aw();
    test_decode_err();
    test_read_only();
    test_back_to_back();
    test_collision();
    test_random();
    test_reset_pending_read();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_regfile_v3.md
Name: axi4_lite_regfile_v3

Overview:
Parametrised AXI4-Lite slave register file. It generalises the single-width register bank in four ways: any DATA_SIZE that is a multiple of 8, full address decode with error responses, per-register read-only masking, and hardware-side update ports. AW and W are accepted independently and joined internally. It sits between the interconnect and a peripheral core, exposing all registers as a flat vector.

Parameters:
ADDRESS_SIZE, 32, AXI address width.
DATA_SIZE, 32, data width; must be a multiple of 8 (32 or 64 in practice).
REGISTERS, 4, number of registers (>=1).
READ_ONLY_MASK, '0 (REGISTERS bits), bit i=1 makes register i bus-read-only.
RESET_VALUE, '0 (REGISTERS*DATA_SIZE bits), flat reset image; register i = slice [i*DATA_SIZE +: DATA_SIZE].

Ports:
clk_i  in  1  clock
rst_clk_i  in  1  reset; one clock, synchronous, active-high
s_axi_awaddr/awvalid/awready  in/in/out  ADDRESS_SIZE/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_SIZE/DATA_SIZE/8/1/1  write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
s_axi_araddr/arvalid/arready  in/in/out  ADDRESS_SIZE/1/1  read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_SIZE/2/1/1  read data channel
regs_o  out  REGISTERS*DATA_SIZE  current register contents, flat
reg_written_o  out  REGISTERS  one-cycle pulse when a bus write commits to register i
hw_we_i  in  REGISTERS  hardware write enable per register
hw_wdata_i  in  REGISTERS*DATA_SIZE  hardware write data, flat

Behaviour:
- Reset (rst_clk_i=1 at an edge): registers <= RESET_VALUE; awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; reg_written_o=0. Held AW/W/AR state is discarded; an in-flight response is dropped.
- Decode: OFFS = $clog2(DATA_SIZE/8). idx = addr >> OFFS. Low OFFS bits are ignored, so unaligned addresses are aligned down.
- Error responses: idx >= REGISTERS gives SLVERR (2'b10). A write to a READ_ONLY_MASK register gives SLVERR with no change and no reg_written_o pulse. A read of a read-only register is OKAY.
- Write path, joiner stage:
  - awready = !aw_held; wready = !w_held.
  - Each handshake captures into its own holding register.
  - AW and W may arrive in the same cycle or in either order, any cycles apart.
- Write path, commit stage:
  - Fires in the cycle where aw_held && w_held && !bvalid.
  - Per byte b: reg[idx][8b+:8] <= wstrb[b] ? wdata[8b+:8] : old.
  - Same edge: bvalid<=1, bresp set, reg_written_o[idx] pulses one cycle, both held flags clear.
  - Both handshakes in cycle N gives commit and bvalid at edge N+1.
- B channel: bvalid stays until bvalid&&bready. Held flags stay set while bvalid=1, so at most one more AW and one more W are buffered.
- Read path:
  - arready = !rvalid.
  - An AR handshake at edge N loads rdata/rresp and sets rvalid at N+1.
  - rdata = 0 on SLVERR.
  - rvalid and rdata stay stable until rready; a new AR is accepted in the cycle after rvalid&&rready.
- Read/write collision: a read sampled in the same cycle as a commit to the same register returns the old value.
- Hardware/bus collision: if hw_we_i[i] and a bus commit to i occur in the same cycle, hardware wins the whole register. bresp is still OKAY and reg_written_o[i] still pulses.
- hw_we_i updates land at the next edge and ignore READ_ONLY_MASK.
- Read and write channels are fully independent, with no arbitration stall.

Decomposition:
- Package axi4_lite_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Function addr_to_index(addr, data_size).
  - Localparam for strobe width.
- Sub-module axi4_lite_aw_w_joiner: the AW/W holding registers plus the ready logic. Outputs: joined valid, addr, data, strb; input: consume. The top level owns the register array, decode, B and R channels.

Test Plan:
- Reset with RESET_VALUE reg1=32'hDEAD_BEEF; read 0x4 -> rdata=32'hDEAD_BEEF, rresp=OKAY, rvalid exactly one cycle after the AR handshake.
- W (0x1122_3344, wstrb=4'b0101) three cycles before AW=0x8, reg2 initially 0xAABB_CCDD -> reg2=0xAA22_CC44, bresp=OKAY, reg_written_o[2] single pulse.
- AW=0x100 (REGISTERS=4) -> bresp=SLVERR, no register changes. Read 0x100 -> rdata=0, rresp=SLVERR.
- READ_ONLY_MASK=4'b0010, write 0x4 -> SLVERR, reg1 unchanged, no pulse. Read 0x4 -> OKAY.
- bready held low for 5 cycles while a second AW+W arrives -> second pair held with awready=wready=0. After B handshake, second commit one cycle later.
- hw_we_i[3]=1 with hw_wdata 0x5 in the same cycle as a bus commit of 0x9 to reg3 -> reg3=0x5. Assert rst_clk_i during a pending rvalid -> rvalid=0 next cycle, registers back to RESET_VALUE.
